pmem_arbiter: RTL and testbench



---
 rtl/pmem_arbiter.sv | 124 ++++++++++++
 tb/tb_pmem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Program memory arbiter: CPU fetch path vs. loader/debug port.
// Starvation-bounded arbitration with lock, one access per cycle, 1-cycle read return.
module pmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic              FetchGnt,
    output logic              FetchValid,
    output logic [DATA_W-1:0] FetchData,
    output logic              Stall,
    input  logic              LoadReq,
    input  logic              LoadWe,
    input  logic              LoadLock,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadWData,
    output logic              LoadGnt,
    output logic              LoadValid,
    output logic [DATA_W-1:0] LoadRData,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    owner_t           owner_q;
    owner_t           owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_d;
    logic             lock_q;
    logic             pend_f;
    logic             pend_d;
    logic             starved;

    assign starved = (starve_cnt == LIM);

    always_comb begin
        FetchGnt = 1'b0;
        LoadGnt  = 1'b0;
        priority case (1'b1)
            lock_q & LoadReq:             LoadGnt  = 1'b1;
            FetchReq & LoadReq & starved: FetchGnt = 1'b1;
            LoadReq:                      LoadGnt  = 1'b1;
            FetchReq:                     FetchGnt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        MemEn    = FetchGnt | LoadGnt;
        MemWe    = LoadGnt & LoadWe;
        MemAddr  = '0;
        MemWData = '0;
        if (FetchGnt) begin
            MemAddr = FetchAddr;
        end else if (LoadGnt) begin
            MemAddr  = LoadAddr;
            MemWData = LoadWData;
        end
    end

    // Counter only measures an uninterrupted wait by the fetch path
    always_comb begin
        starve_d = starve_cnt;
        if (!FetchReq || FetchGnt) begin
            starve_d = '0;
        end else if (LoadGnt && starve_cnt < LIM) begin
            starve_d = starve_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (FetchGnt) begin
            owner_d = OWN_FETCH;
        end else if (LoadGnt && !LoadWe) begin
            owner_d = OWN_LOAD;
        end
    end

    always_comb begin
        pend_d = pend_f;
        if (FetchGnt) begin
            pend_d = 1'b1;
        end else if (FetchValid) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
            lock_q     <= 1'b0;
            pend_f     <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
            lock_q     <= LoadGnt & LoadLock;
            pend_f     <= pend_d;
        end
    end

    assign FetchValid = (owner_q == OWN_FETCH);
    assign LoadValid  = (owner_q == OWN_LOAD);
    assign FetchData  = FetchValid ? MemRData : '0;
    assign LoadRData  = LoadValid ? MemRData : '0;
    assign Stall      = (FetchReq & ~FetchGnt) | (pend_f & ~FetchValid);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter with a behavioural memory and
// a rule-level arbitration model driven by directed and random traffic.
module tb_pmem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic          CLK = 1'b0;
    logic          CLB = 1'b0;
    logic          FetchReq = 1'b0;
    logic [AW-1:0] FetchAddr = '0;
    logic          FetchGnt;
    logic          FetchValid;
    logic [DW-1:0] FetchData;
    logic          Stall;
    logic          LoadReq = 1'b0;
    logic          LoadWe = 1'b0;
    logic          LoadLock = 1'b0;
    logic [AW-1:0] LoadAddr = '0;
    logic [DW-1:0] LoadWData = '0;
    logic          LoadGnt;
    logic          LoadValid;
    logic [DW-1:0] LoadRData;
    logic          MemEn;
    logic          MemWe;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic [DW-1:0] MemRData;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .CLK(CLK), .CLB(CLB),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt),
        .FetchValid(FetchValid), .FetchData(FetchData), .Stall(Stall),
        .LoadReq(LoadReq), .LoadWe(LoadWe), .LoadLock(LoadLock),
        .LoadAddr(LoadAddr), .LoadWData(LoadWData), .LoadGnt(LoadGnt),
        .LoadValid(LoadValid), .LoadRData(LoadRData),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemRData(MemRData)
    );

    function automatic logic [DW-1:0] init_val(int i);
        return DW'(i * 37 + 26);
    endfunction

    // Behavioural synchronous single-port RAM
    logic [DW-1:0] ram [256];
    logic [DW-1:0] mem_rdata = '0;
    logic          ram_ready = 1'b0;

    always @(posedge CLK) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (MemEn) begin
            if (MemWe) ram[MemAddr] <= MemWData;
            else mem_rdata <= ram[MemAddr];
        end
    end
    assign MemRData = mem_rdata;

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    int            m_cnt;
    bit            m_lock;
    bit            m_pend;
    int            m_owner;
    logic [DW-1:0] m_rd;

    logic          e_fg, e_lg, e_en, e_we, e_fv, e_lv, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_fd, e_ld;

    task automatic model_reset();
        m_cnt = 0;
        m_lock = 0;
        m_pend = 0;
        m_owner = 0;
        m_rd = '0;
    endtask

    task automatic predict();
        e_fv = (m_owner == 1);
        e_lv = (m_owner == 2);
        e_fd = e_fv ? m_rd : '0;
        e_ld = e_lv ? m_rd : '0;
        e_fg = 1'b0;
        e_lg = 1'b0;
        if (m_lock && LoadReq) e_lg = 1'b1;
        else if (FetchReq && LoadReq && m_cnt == LIM) e_fg = 1'b1;
        else if (LoadReq) e_lg = 1'b1;
        else if (FetchReq) e_fg = 1'b1;
        e_en = e_fg | e_lg;
        e_we = e_lg & LoadWe;
        e_addr = e_fg ? FetchAddr : (e_lg ? LoadAddr : '0);
        e_wdata = e_lg ? LoadWData : '0;
        e_stall = (FetchReq & ~e_fg) | (m_pend & ~e_fv);
    endtask

    task automatic commit();
        if (e_en && !e_we) m_rd = ref_mem[e_addr];
        if (e_we) ref_mem[e_addr] = e_wdata;
        m_owner = e_fg ? 1 : ((e_lg && !LoadWe) ? 2 : 0);
        if (e_fg) m_pend = 1;
        else if (e_fv) m_pend = 0;
        m_lock = e_lg & LoadLock;
        if (!FetchReq || e_fg) m_cnt = 0;
        else if (e_lg && m_cnt < LIM) m_cnt = m_cnt + 1;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (CLB) commit();
        else model_reset();
        #1;
    endtask

    task automatic idle();
        FetchReq = 0;
        LoadReq = 0;
        LoadLock = 0;
        LoadWe = 0;
        predict();
        tick();
    endtask

    task automatic test_reset();
        CLB = 0;
        FetchReq = 1;
        LoadReq = 1;
        model_reset();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            predict();
            #3;
            checks++;
            if (FetchValid !== 1'b0 || LoadValid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid got=%b%b want=00", FetchValid, LoadValid);
            end
            checks++;
            if (dut.starve_cnt !== '0) begin
                failures++;
                $display("FAIL reset_starve got=%0d want=0", dut.starve_cnt);
            end
            tick();
        end
        CLB = 1;
        LoadReq = 0;
        FetchAddr = 8'h05;
        predict();
        #3;
        checks++;
        if (FetchGnt !== 1'b1 || Stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_fetch gnt=%b stall=%b want gnt=1 stall=0", FetchGnt, Stall);
        end
        tick();
        FetchReq = 0;
        predict();
        #3;
        checks++;
        if (FetchValid !== 1'b1 || FetchData !== 8'hD3 || Stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_data valid=%b data=%h stall=%b want 1 d3 0", FetchValid, FetchData, Stall);
        end
        tick();
    endtask

    task automatic test_write_then_fetch();
        LoadReq = 1;
        LoadWe = 1;
        LoadAddr = 8'h10;
        LoadWData = 8'hF0;
        predict();
        #3;
        checks++;
        if (LoadGnt !== 1'b1 || MemEn !== 1'b1 || MemWe !== 1'b1 || MemAddr !== 8'h10 || MemWData !== 8'hF0) begin
            failures++;
            $display("FAIL write_cmd gnt=%b en=%b we=%b addr=%h wd=%h want 1 1 1 10 f0", LoadGnt, MemEn, MemWe, MemAddr, MemWData);
        end
        tick();
        LoadReq = 0;
        LoadWe = 0;
        FetchReq = 1;
        FetchAddr = 8'h10;
        predict();
        #3;
        checks++;
        if (LoadValid !== 1'b0 || FetchGnt !== 1'b1 || MemWe !== 1'b0) begin
            failures++;
            $display("FAIL write_noresp lvalid=%b fgnt=%b we=%b want 0 1 0", LoadValid, FetchGnt, MemWe);
        end
        tick();
        FetchReq = 0;
        predict();
        #3;
        checks++;
        if (FetchValid !== 1'b1 || FetchData !== 8'hF0) begin
            failures++;
            $display("FAIL write_readback valid=%b data=%h want 1 f0", FetchValid, FetchData);
        end
        tick();
    endtask

    task automatic test_starvation();
        idle();
        FetchReq = 1;
        LoadReq = 1;
        LoadWe = 0;
        for (int i = 0; i < 10; i++) begin
            FetchAddr = AW'(8'h20 + i);
            LoadAddr = AW'(8'h40 + i);
            predict();
            #3;
            checks++;
            if (FetchGnt !== (i % 5 == 4) || LoadGnt !== (i % 5 != 4) || Stall !== (i % 5 != 4)) begin
                failures++;
                $display("FAIL starve_seq cyc=%0d fgnt=%b lgnt=%b stall=%b want fgnt=%b", i, FetchGnt, LoadGnt, Stall, (i % 5 == 4));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_lock();
        idle();
        FetchReq = 1;
        LoadReq = 1;
        LoadWe = 0;
        LoadLock = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) LoadLock = 0;
            predict();
            #3;
            checks++;
            if (FetchGnt !== (i == 9) || LoadGnt !== (i != 9)) begin
                failures++;
                $display("FAIL lock_seq cyc=%0d fgnt=%b lgnt=%b want fgnt=%b", i, FetchGnt, LoadGnt, (i == 9));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_interleave();
        FetchReq = 1;
        FetchAddr = 8'h01;
        predict();
        tick();
        FetchReq = 0;
        LoadReq = 1;
        LoadWe = 0;
        LoadAddr = 8'h02;
        predict();
        #3;
        checks++;
        if (FetchValid !== 1'b1 || LoadValid !== 1'b0 || FetchData !== init_val(1)) begin
            failures++;
            $display("FAIL interleave_f1 fv=%b lv=%b fd=%h want 1 0 %h", FetchValid, LoadValid, FetchData, init_val(1));
        end
        tick();
        LoadReq = 0;
        FetchReq = 1;
        FetchAddr = 8'h03;
        predict();
        #3;
        checks++;
        if (FetchValid !== 1'b0 || LoadValid !== 1'b1 || LoadRData !== init_val(2) || FetchData !== 8'h00) begin
            failures++;
            $display("FAIL interleave_l2 fv=%b lv=%b ld=%h fd=%h want 0 1 %h 00", FetchValid, LoadValid, LoadRData, FetchData, init_val(2));
        end
        tick();
        FetchReq = 0;
        predict();
        #3;
        checks++;
        if (FetchValid !== 1'b1 || LoadValid !== 1'b0 || FetchData !== init_val(3) || LoadRData !== 8'h00) begin
            failures++;
            $display("FAIL interleave_f3 fv=%b lv=%b fd=%h ld=%h want 1 0 %h 00", FetchValid, LoadValid, FetchData, LoadRData, init_val(3));
        end
        tick();
    endtask

    task automatic test_no_request();
        FetchAddr = 8'h55;
        LoadAddr = 8'h66;
        LoadWData = 8'h77;
        idle();
        predict();
        #3;
        checks++;
        if (FetchGnt !== 1'b0 || LoadGnt !== 1'b0 || MemEn !== 1'b0 || MemAddr !== 8'h00 || MemWData !== 8'h00) begin
            failures++;
            $display("FAIL no_request fg=%b lg=%b en=%b addr=%h wd=%h want 0 0 0 00 00", FetchGnt, LoadGnt, MemEn, MemAddr, MemWData);
        end
        tick();
    endtask

    task automatic test_mid_read_reset();
        FetchReq = 1;
        FetchAddr = 8'h07;
        predict();
        tick();
        FetchReq = 0;
        CLB = 0;
        model_reset();
        #3;
        checks++;
        if (FetchValid !== 1'b0 || Stall !== 1'b0) begin
            failures++;
            $display("FAIL midreset_drop fv=%b stall=%b want 0 0", FetchValid, Stall);
        end
        tick();
        CLB = 1;
        predict();
        #3;
        checks++;
        if (FetchValid !== 1'b0 || LoadValid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_after fv=%b lv=%b want 0 0", FetchValid, LoadValid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [38:0] got;
        logic [38:0] want;
        for (int i = 0; i < 300; i++) begin
            FetchReq = ($urandom_range(0, 3) != 0);
            LoadReq = ($urandom_range(0, 2) != 0);
            LoadWe = ($urandom_range(0, 3) == 0);
            LoadLock = ($urandom_range(0, 4) == 0);
            FetchAddr = AW'($urandom_range(0, 31));
            LoadAddr = AW'($urandom_range(0, 31));
            LoadWData = DW'($urandom);
            predict();
            #3;
            got = {FetchGnt, LoadGnt, MemEn, MemWe, MemAddr, MemWData,
                   FetchValid, FetchData, LoadValid, LoadRData, Stall};
            want = {e_fg, e_lg, e_en, e_we, e_addr, e_wdata,
                    e_fv, e_fd, e_lv, e_ld, e_stall};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, got, want);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        test_reset();
        test_write_then_fetch();
        test_starvation();
        test_lock();
        test_interleave();
        test_no_request();
        test_mid_read_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
